accfifo_swap_ctrl: RTL and testbench

Controller for the double-buffered accumulation FIFO pair in each PE column. It tracks words written into the compute FIFO per tile. On tile completion it flips which_fifo_to_compute once the shadow FIFO has been fully drained. It streams the shadow FIFO contents to the global buffer over a valid/ready port through a one-entry output register.

---
 rtl/accfifo_swap_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_accfifo_swap_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accfifo_swap_ctrl.sv
// accfifo_swap_ctrl
//   Swap and drain controller for the double-buffered accumulation FIFO pair
//   of one PE column. It counts the words the PE writes into the compute FIFO
//   for each tile. At tile completion it flips which_fifo_to_compute, but only
//   once the previous shadow FIFO has been fully drained; until then it stalls
//   the PE. The shadow FIFO is streamed to the global buffer through a
//   one-entry valid/ready output register.
//
//   Optional build macro: ACCFIFO_CTRL_PERF_EN adds the stall_cycles counter port.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   tile_done              one-cycle pulse: last accumulation of the tile issued
//   compute_fifo_write     write strobe into the compute FIFO (observed only)
//   compute_stall          PE must not write or pulse tile_done while high
//   which_fifo_to_compute  compute FIFO select (0: FIFO0 computes)
//   shadow_fifo_read       pop strobe to the shadow FIFO (combinational)
//   shadow_fifo_empty      shadow FIFO empty flag
//   shadow_fifo_data_out   shadow FIFO head word (show-ahead)
//   gb_valid/gb_data/gb_last/gb_ready  output stream to the global buffer
//   drain_busy             words still owed to the global buffer
//   protocol_err           sticky: overflow write, or write/tile_done while stalled
//   stall_cycles           (perf build only) saturating count of stalled cycles
//
// States
//   RUN  | PE computes freely; tile_done swaps at once if the drain is idle
//   PEND | tile finished while draining; PE stalled until the drain is idle
module accfifo_swap_ctrl #(
    parameter int NB_DATA      = 32,
    parameter int OUTPUT_WIDTH = 24,
    parameter int CNT_W        = $clog2(NB_DATA + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tile_done,
    input  logic                    compute_fifo_write,
    output logic                    compute_stall,
    output logic                    which_fifo_to_compute,
    output logic                    shadow_fifo_read,
    input  logic                    shadow_fifo_empty,
    input  logic [OUTPUT_WIDTH-1:0] shadow_fifo_data_out,
    output logic                    gb_valid,
    output logic [OUTPUT_WIDTH-1:0] gb_data,
    output logic                    gb_last,
    input  logic                    gb_ready,
    output logic                    drain_busy,
    output logic                    protocol_err
`ifdef ACCFIFO_CTRL_PERF_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NB_DATA);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] wr_cnt_inc;
    logic [CNT_W-1:0] pend_cnt;
    logic [CNT_W-1:0] swap_cnt;
    logic [CNT_W-1:0] drain_remaining;
    logic             swap;
    logic             freeze;
    logic             pop;
    logic             handshake;
    logic             err_set;

    // Saturating count including a write in the current cycle.
    assign wr_cnt_inc = (compute_fifo_write && (wr_cnt != CNT_FULL)) ? wr_cnt + CNT_ONE : wr_cnt;

    assign drain_busy    = (drain_remaining != '0) || gb_valid;
    assign compute_stall = (state == ST_PEND);

    // A pending swap uses the count frozen at tile_done, not the live counter.
    assign swap_cnt = (state == ST_RUN) ? wr_cnt_inc : pend_cnt;

    assign pop              = (drain_remaining != '0) && !shadow_fifo_empty && (!gb_valid || gb_ready);
    assign shadow_fifo_read = pop;
    assign handshake        = gb_valid && gb_ready;

    assign err_set = (compute_fifo_write && (wr_cnt == CNT_FULL))
                   || (compute_stall && (compute_fifo_write || tile_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // tile_done is only acted on in RUN; in PEND it is a protocol error and ignored.
    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        freeze    = 1'b0;
        case (state)
            ST_RUN: begin
                if (tile_done) begin
                    if (!drain_busy) begin
                        swap = 1'b1;
                    end else begin
                        freeze    = 1'b1;
                        state_nxt = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!drain_busy) begin
                    swap      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // The finished tile's count moves to pend_cnt on freeze, so wr_cnt restarts
    // there; illegal writes made while stalled keep accumulating in wr_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            pend_cnt <= '0;
        end else begin
            if ((swap && (state == ST_RUN)) || freeze) begin
                wr_cnt <= '0;
            end else begin
                wr_cnt <= wr_cnt_inc;
            end
            if (freeze) begin
                pend_cnt <= wr_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            which_fifo_to_compute <= 1'b0;
        end else if (swap) begin
            which_fifo_to_compute <= ~which_fifo_to_compute;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            protocol_err <= 1'b0;
        end else if (err_set) begin
            protocol_err <= 1'b1;
        end
    end

    // Swap requires drain_remaining==0, so load and decrement never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_remaining <= '0;
        end else if (swap) begin
            drain_remaining <= swap_cnt;
        end else if (pop) begin
            drain_remaining <= drain_remaining - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gb_valid <= 1'b0;
            gb_data  <= '0;
            gb_last  <= 1'b0;
        end else if (pop) begin
            gb_valid <= 1'b1;
            gb_data  <= shadow_fifo_data_out;
            gb_last  <= (drain_remaining == CNT_ONE);
        end else if (handshake) begin
            gb_valid <= 1'b0;
            gb_last  <= 1'b0;
        end
    end

`ifdef ACCFIFO_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (compute_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_accfifo_swap_ctrl.sv
// Testbench for accfifo_swap_ctrl: models the double-buffered FIFO pair,
// queues expected global-buffer words at each tile_done and checks them in a
// separate monitor, plus directed checks on control outputs.
module tb_accfifo_swap_ctrl;

    localparam int NB_DATA = 32;
    localparam int OW      = 24;
    localparam int CNT_W   = $clog2(NB_DATA + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tile_done = 1'b0;
    logic          compute_fifo_write = 1'b0;
    logic          compute_stall;
    logic          which_fifo_to_compute;
    logic          shadow_fifo_read;
    logic          shadow_fifo_empty = 1'b1;
    logic [OW-1:0] shadow_fifo_data_out = '0;
    logic          gb_valid;
    logic [OW-1:0] gb_data;
    logic          gb_last;
    logic          gb_ready = 1'b1;
    logic          drain_busy;
    logic          protocol_err;
`ifdef ACCFIFO_CTRL_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    logic [OW-1:0] wdata = '0;

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [OW-1:0] fifo0[$];
    logic [OW-1:0] fifo1[$];
    logic [OW-1:0] tile_q[$];

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;
    int hs_cnt   = 0;

    accfifo_swap_ctrl #(.NB_DATA(NB_DATA), .OUTPUT_WIDTH(OW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .tile_done             (tile_done),
        .compute_fifo_write    (compute_fifo_write),
        .compute_stall         (compute_stall),
        .which_fifo_to_compute (which_fifo_to_compute),
        .shadow_fifo_read      (shadow_fifo_read),
        .shadow_fifo_empty     (shadow_fifo_empty),
        .shadow_fifo_data_out  (shadow_fifo_data_out),
        .gb_valid              (gb_valid),
        .gb_data               (gb_data),
        .gb_last               (gb_last),
        .gb_ready              (gb_ready),
        .drain_busy            (drain_busy),
        .protocol_err          (protocol_err)
`ifdef ACCFIFO_CTRL_PERF_EN
        ,
        .stall_cycles          (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // FIFO pair model: writes go to the compute FIFO, pops from the other one.
    always @(posedge clk) begin
        if (rst_n) begin
            if (compute_fifo_write) begin
                if (which_fifo_to_compute) fifo1.push_back(wdata);
                else                       fifo0.push_back(wdata);
            end
            if (shadow_fifo_read) begin
                pop_cnt++;
                if (which_fifo_to_compute) begin
                    if (fifo0.size() > 0) void'(fifo0.pop_front());
                end else begin
                    if (fifo1.size() > 0) void'(fifo1.pop_front());
                end
            end
        end
    end

    // Shadow flags only matter at the rising edge, so refresh them mid-cycle.
    always @(negedge clk) begin
        if (which_fifo_to_compute) begin
            shadow_fifo_empty    = (fifo0.size() == 0);
            shadow_fifo_data_out = (fifo0.size() == 0) ? '0 : fifo0[0];
        end else begin
            shadow_fifo_empty    = (fifo1.size() == 0);
            shadow_fifo_data_out = (fifo1.size() == 0) ? '0 : fifo1[0];
        end
    end

    // Monitor: every handshake about to happen must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && gb_valid && gb_ready) begin
            hs_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_extra_word got data=%h last=%b expected none", gb_data, gb_last);
            end else begin
                e = sb.pop_front();
                if ((gb_data !== e.data) || (gb_last !== e.last)) begin
                    failures++;
                    $display("FAIL sb_word got data=%h last=%b expected data=%h last=%b",
                             gb_data, gb_last, e.data, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic do_write(input logic [OW-1:0] d);
        compute_fifo_write = 1'b1;
        wdata              = d;
        tile_q.push_back(d);
        tick();
        compute_fifo_write = 1'b0;
    endtask

    task automatic push_tile();
        exp_t x;
        for (int i = 0; i < tile_q.size(); i++) begin
            x.data = tile_q[i];
            x.last = (i == tile_q.size() - 1);
            sb.push_back(x);
        end
        tile_q.delete();
    endtask

    task automatic do_tile_done();
        push_tile();
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (drain_busy && (n < max_cycles)) begin
            tick();
            n++;
        end
        chk("drain_idle_timeout", {31'd0, drain_busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, h0, n;

        // Reset state
        repeat (3) tick();
        chk("rst_which", {31'd0, which_fifo_to_compute}, 32'd0);
        chk("rst_stall", {31'd0, compute_stall}, 32'd0);
        chk("rst_gb_valid", {31'd0, gb_valid}, 32'd0);
        chk("rst_gb_data", {8'd0, gb_data}, 32'd0);
        chk("rst_gb_last", {31'd0, gb_last}, 32'd0);
        chk("rst_err", {31'd0, protocol_err}, 32'd0);
        chk("rst_busy", {31'd0, drain_busy}, 32'd0);
        chk("rst_read", {31'd0, shadow_fifo_read}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic 5-word tile
        for (int i = 0; i < 5; i++) do_write(24'h000100 + 24'(i));
        p0 = pop_cnt; h0 = hs_cnt;
        do_tile_done();
        chk("t1_which", {31'd0, which_fifo_to_compute}, 32'd1);
        wait_idle(50);
        chk("t1_pops", 32'(pop_cnt - p0), 32'd5);
        chk("t1_hs", 32'(hs_cnt - h0), 32'd5);

        // 8 words with gb_ready held low after the first pop
        for (int i = 0; i < 8; i++) do_write(24'h000200 + 24'(i));
        gb_ready = 1'b0;
        p0 = pop_cnt; h0 = hs_cnt;
        do_tile_done();
        chk("t2_which", {31'd0, which_fifo_to_compute}, 32'd0);
        tick();
        chk("t2_valid", {31'd0, gb_valid}, 32'd1);
        chk("t2_data", {8'd0, gb_data}, 32'h000200);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_valid", {31'd0, gb_valid}, 32'd1);
            chk("t2_hold_data", {8'd0, gb_data}, 32'h000200);
        end
        chk("t2_one_pop", 32'(pop_cnt - p0), 32'd1);
        gb_ready = 1'b1;
        wait_idle(50);
        chk("t2_hs", 32'(hs_cnt - h0), 32'd8);

        // Tile B finishes while tile A is still draining -> PEND
        for (int i = 0; i < 8; i++) do_write(24'h000300 + 24'(i));
        gb_ready = 1'b0;
        do_tile_done();
        for (int i = 0; i < 4; i++) do_write(24'h000400 + 24'(i));
        do_tile_done();
        chk("t3_stall", {31'd0, compute_stall}, 32'd1);
        chk("t3_which_held", {31'd0, which_fifo_to_compute}, 32'd1);
        chk("t3_err", {31'd0, protocol_err}, 32'd0);
        gb_ready = 1'b1;
        n = 0;
        while (compute_stall && (n < 100)) begin tick(); n++; end
        chk("t3_stall_drop", {31'd0, compute_stall}, 32'd0);
        chk("t3_which", {31'd0, which_fifo_to_compute}, 32'd0);
        wait_idle(50);

        // Write in the same cycle as tile_done
        do_write(24'h000500);
        do_write(24'h000501);
        compute_fifo_write = 1'b1;
        wdata = 24'h000502;
        tile_q.push_back(24'h000502);
        do_tile_done();
        compute_fifo_write = 1'b0;
        chk("t4_drain_cnt", 32'(dut.drain_remaining), 32'd3);
        chk("t4_which", {31'd0, which_fifo_to_compute}, 32'd1);
        wait_idle(50);

        // NB_DATA+1 writes: saturation and sticky error
        for (int i = 0; i < NB_DATA; i++) do_write(24'h000600 + 24'(i));
        chk("t5_no_err", {31'd0, protocol_err}, 32'd0);
        do_write(24'h0006FF);
        void'(tile_q.pop_back());
        chk("t5_err", {31'd0, protocol_err}, 32'd1);
        chk("t5_wr_cnt", 32'(dut.wr_cnt), 32'(NB_DATA));
        do_tile_done();
        wait_idle(100);
        chk("t5_err_sticky", {31'd0, protocol_err}, 32'd1);

        // Reset after 3 of 8 words delivered
        for (int i = 0; i < 8; i++) do_write(24'h000700 + 24'(i));
        h0 = hs_cnt;
        do_tile_done();
        n = 0;
        while (((hs_cnt - h0) < 3) && (n < 50)) begin tick(); n++; end
        chk("t6_three_sent", 32'(hs_cnt - h0), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'd0, gb_valid}, 32'd0);
        chk("t6_which", {31'd0, which_fifo_to_compute}, 32'd0);
        chk("t6_busy", {31'd0, drain_busy}, 32'd0);
        sb.delete();
        tile_q.delete();
        p0 = pop_cnt;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("t6_no_pops", 32'(pop_cnt - p0), 32'd0);
        chk("t6_err_clr", {31'd0, protocol_err}, 32'd0);
        fifo0.delete();
        fifo1.delete();
        tick();

        // Write while stalled in PEND
        for (int i = 0; i < 4; i++) do_write(24'h000800 + 24'(i));
        gb_ready = 1'b0;
        do_tile_done();
        do_write(24'h000900);
        do_write(24'h000901);
        do_tile_done();
        chk("t7_stall", {31'd0, compute_stall}, 32'd1);
        compute_fifo_write = 1'b1;
        wdata = 24'h0009FF;
        tick();
        compute_fifo_write = 1'b0;
        chk("t7_err", {31'd0, protocol_err}, 32'd1);
        gb_ready = 1'b1;
        n = 0;
        while (compute_stall && (n < 100)) begin tick(); n++; end
        chk("t7_stall_drop", {31'd0, compute_stall}, 32'd0);
        wait_idle(50);
        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
